bool_tt_engine: RTL and testbench
=================================

// Module: bool_tt_engine
// PURPOSE
//   Parametrised, run-time programmable Boolean function block. Holds a 2^N_IN-entry
//   truth table that is loaded in beats over a valid/ready port. It evaluates any
//   input vector with one cycle of latency.
//   A sweep mode walks every minterm and reports the ON-set size, so software and
//   benches can check a loaded function against its simplified form.
//   It is the generic successor to the fixed 5-input sum-of-minterms logic blocks.
// PARAMETERS
//   N_IN     5    number of function inputs; table depth TT_D = 2^N_IN
//   LOAD_W   8    bits per load beat; TT_D must be a multiple of LOAD_W (BEATS = TT_D/LOAD_W)
//   INIT_TT  0    TT_D-bit table value applied at reset; bit i = output for in_vec==i
// PORTS
//   clk          in   1        single clock, rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   in_vec       in   N_IN     input vector to evaluate
//   in_valid     in   1        evaluate in_vec this cycle
//   out          out  1        registered function value
//   out_valid    out  1        out updated this cycle
//   ld_start     in   1        begin/restart a table load
//   ld_data      in   LOAD_W   load beat, LSB = lowest minterm index of the beat
//   ld_valid     in   1        ld_data is valid
//   ld_ready     out  1        block accepts a beat (high only in LOAD)
//   sweep_start  in   1        begin ON-set count
//   sweep_busy   out  1        sweep in progress
//   sweep_done   out  1        one-cycle pulse, sweep_count final
//   sweep_count  out  N_IN+1   number of 1 bits in table (range 0..TT_D)
// BEHAVIOUR
//   Reset (async): state=IDLE, TT=INIT_TT, out/out_valid/sweep_busy/sweep_done/ld_ready=0,
//     sweep_count=0, beat/index counters=0. Reset mid-load or mid-sweep aborts the operation.
//   FSM IDLE/LOAD/SWEEP:
//     IDLE : ld_start -> LOAD with beat=0; else sweep_start -> SWEEP with idx=0, count=0.
//            ld_start has priority when both are asserted. ld_valid is ignored.
//     LOAD : ld_ready=1. A beat is accepted when ld_valid&ld_ready, with
//            TT[beat*LOAD_W +: LOAD_W] <= ld_data and beat++. After beat BEATS-1 is accepted
//            -> IDLE, ld_ready=0 next cycle. ld_start in LOAD resets beat=0; previously
//            written beats are kept. ld_start has priority over a beat in the same cycle.
//            sweep_start is ignored.
//     SWEEP: each cycle count += TT[idx] and idx++. This takes exactly TT_D cycles with
//            sweep_busy=1. After idx TT_D-1: -> IDLE, sweep_done=1 for exactly one cycle,
//            and sweep_count=final value. sweep_count holds until the next sweep start.
//            ld_start, sweep_start and ld_valid are ignored; ld_ready=0.
//   Evaluation (all states): on in_valid, out <= TT[in_vec] at the next edge, and out_valid
//     <= in_valid (latency 1). out holds its value when in_valid=0. A table write in the same
//     cycle is not visible; the old bit is returned.
//   Width: the count needs N_IN+1 bits so that an all-ones table gives TT_D without wrap.
//     The beat counter wraps only through the FSM exit, never modulo.
// TESTING (N_IN=5, LOAD_W=8, INIT_TT=0)
//   Reset, then in_vec=5'd3 with in_valid -> next cycle out=0, out_valid=1; ld_ready=0, sweep_count=0.
//   ld_start, then beats FF,00,A5,01 (with ld_valid gaps) -> TT=32'h01A500FF; eval 0,8,16,17,24,31 -> 1,0,1,0,1,0.
//   sweep_start after that load -> sweep_busy for 32 cycles, then sweep_done for 1 cycle with sweep_count=13.
//   Load FF x4, then sweep -> sweep_count=6'd32 (no wrap); ld_start+sweep_start together in IDLE -> LOAD entered.
//   ld_start after 2 beats, then 4 beats 11,22,33,44 -> TT=32'h44332211; ld_valid in IDLE or SWEEP -> TT unchanged.
//   rst_n low at sweep cycle 10 -> immediate IDLE, sweep_busy=0, no sweep_done, TT=0, sweep_count=0.

Source files
------------

// File: rtl/bool_tt_engine.sv
// Run-time programmable N_IN-input Boolean function: beat-loaded truth table,
// one-cycle registered evaluation, and an ON-set counting sweep.
module bool_tt_engine #(
  parameter int unsigned               N_IN    = 5,
  parameter int unsigned               LOAD_W  = 8,
  parameter logic [(1 << N_IN)-1:0]    INIT_TT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_vec,
  input  logic              in_valid,
  output logic              out,
  output logic              out_valid,
  input  logic              ld_start,
  input  logic [LOAD_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [N_IN:0]     sweep_count
);

  localparam int unsigned TT_D  = 1 << N_IN;
  localparam int unsigned BEATS = TT_D / LOAD_W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP
  } state_t;

  state_t            r_state;
  logic [TT_D-1:0]   r_tt;
  logic [BW-1:0]     r_beat;
  logic [N_IN-1:0]   r_idx;
  logic [N_IN:0]     r_count;
  logic              r_out;
  logic              r_out_valid;
  logic              r_ld_ready;
  logic              r_sweep_busy;
  logic              r_sweep_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tt         <= INIT_TT;
      r_beat       <= '0;
      r_idx        <= '0;
      r_count      <= '0;
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_ld_ready   <= 1'b0;
      r_sweep_busy <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      // Evaluation reads the pre-edge table, so a same-cycle write returns the old bit.
      r_out_valid  <= in_valid;
      if (in_valid) r_out <= r_tt[in_vec];
      r_sweep_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (ld_start) begin
            r_state    <= ST_LOAD;
            r_beat     <= '0;
            r_ld_ready <= 1'b1;
          end else if (sweep_start) begin
            r_state      <= ST_SWEEP;
            r_idx        <= '0;
            r_count      <= '0;
            r_sweep_busy <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (ld_start) begin
            r_beat <= '0;
          end else if (ld_valid && r_ld_ready) begin
            r_tt[r_beat*LOAD_W +: LOAD_W] <= ld_data;
            if (r_beat == LAST_BEAT) begin
              r_state    <= ST_IDLE;
              r_beat     <= '0;
              r_ld_ready <= 1'b0;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end

        ST_SWEEP: begin
          r_count <= r_count + {{N_IN{1'b0}}, r_tt[r_idx]};
          r_idx   <= r_idx + N_IN'(1);
          if (r_idx == '1) begin
            r_state      <= ST_IDLE;
            r_sweep_busy <= 1'b0;
            r_sweep_done <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_ld_ready   <= 1'b0;
          r_sweep_busy <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign ld_ready    = r_ld_ready;
  assign sweep_busy  = r_sweep_busy;
  assign sweep_done  = r_sweep_done;
  assign sweep_count = r_count;

endmodule

// File: tb/tb_bool_tt_engine.sv
// Randomized bench for bool_tt_engine against a table-level model
// (32-bit word, popcount for sweeps, old-bit semantics on same-cycle writes).
module tb_bool_tt_engine;

  localparam int N_IN   = 5;
  localparam int LOAD_W = 8;
  localparam int TT_D   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_IN-1:0]   in_vec;
  logic              in_valid;
  logic              out;
  logic              out_valid;
  logic              ld_start;
  logic [LOAD_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic [N_IN:0]     sweep_count;

  bool_tt_engine #(
    .N_IN   (N_IN),
    .LOAD_W (LOAD_W),
    .INIT_TT(32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vec     (in_vec),
    .in_valid   (in_valid),
    .out        (out),
    .out_valid  (out_valid),
    .ld_start   (ld_start),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [TT_D-1:0] m_tt  = '0;
  logic            m_out = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock with random evaluation traffic; expectation uses the table as it stood before the edge.
  task automatic cycle();
    logic exp_o;
    logic exp_v;
    in_valid = ($urandom_range(0, 1) == 1);
    in_vec   = N_IN'($urandom);
    exp_v    = in_valid;
    exp_o    = in_valid ? m_tt[in_vec] : m_out;
    @(posedge clk); #1;
    m_out = exp_o;
    check("out", {63'd0, out}, {63'd0, exp_o});
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
  endtask

  task automatic eval_all(input logic [TT_D-1:0] exp_word);
    for (int i = 0; i < TT_D; i++) begin
      in_valid = 1'b1;
      in_vec   = N_IN'(i);
      @(posedge clk); #1;
      m_out = exp_word[i];
      check($sformatf("eval[%0d]", i), {63'd0, out}, {63'd0, exp_word[i]});
      check("eval_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  // Start (or restart) a load and write nbeats beats from beat 0 with random gaps.
  task automatic load_word(input logic [TT_D-1:0] w, input int nbeats);
    ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    check("ld_ready_enter", {63'd0, ld_ready}, 64'd1);
    for (int b = 0; b < nbeats; b++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0;
        ld_data  = LOAD_W'($urandom);
        cycle();
        check("ld_ready_gap", {63'd0, ld_ready}, 64'd1);
      end
      ld_valid = 1'b1;
      ld_data  = w[b*LOAD_W +: LOAD_W];
      cycle();
      m_tt[b*LOAD_W +: LOAD_W] = w[b*LOAD_W +: LOAD_W];
      ld_valid = 1'b0;
    end
    if (nbeats == TT_D / LOAD_W)
      check("ld_ready_exit", {63'd0, ld_ready}, 64'd0);
  endtask

  // Sweep with junk load/start traffic that must be ignored while busy.
  task automatic run_sweep(input int exp_cnt);
    int busy_n;
    int k;
    busy_n      = 0;
    k           = 0;
    sweep_start = 1'b1;
    cycle();
    sweep_start = 1'b0;
    while (sweep_busy && k < 100) begin
      busy_n++;
      if (ld_ready !== 1'b0) check("ld_ready_in_sweep", {63'd0, ld_ready}, 64'd0);
      if (sweep_done !== 1'b0) check("early_done", {63'd0, sweep_done}, 64'd0);
      ld_start    = ($urandom_range(0, 3) == 0);
      sweep_start = ($urandom_range(0, 3) == 0);
      ld_valid    = ($urandom_range(0, 1) == 1);
      ld_data     = LOAD_W'($urandom);
      cycle();
      k++;
    end
    ld_start    = 1'b0;
    sweep_start = 1'b0;
    ld_valid    = 1'b0;
    check("sweep_busy_cycles", 64'(busy_n), 64'(TT_D));
    check("sweep_done", {63'd0, sweep_done}, 64'd1);
    check("sweep_count", {58'd0, sweep_count}, 64'(exp_cnt));
    cycle();
    check("sweep_done_pulse", {63'd0, sweep_done}, 64'd0);
    check("sweep_busy_after", {63'd0, sweep_busy}, 64'd0);
    check("sweep_count_hold", {58'd0, sweep_count}, 64'(exp_cnt));
  endtask

  initial begin
    logic [TT_D-1:0] w;
    rst_n       = 1'b0;
    in_vec      = '0;
    in_valid    = 1'b0;
    ld_start    = 1'b0;
    ld_data     = '0;
    ld_valid    = 1'b0;
    sweep_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {63'd0, out}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    check("rst_busy", {63'd0, sweep_busy}, 64'd0);
    check("rst_done", {63'd0, sweep_done}, 64'd0);
    check("rst_count", {58'd0, sweep_count}, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    in_valid = 1'b1;
    in_vec   = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("first_eval_out", {63'd0, out}, 64'd0);
    check("first_eval_valid", {63'd0, out_valid}, 64'd1);
    check("idle_ld_ready", {63'd0, ld_ready}, 64'd0);
    check("idle_count", {58'd0, sweep_count}, 64'd0);

    load_word(32'h01A5_00FF, 4);
    eval_all(32'h01A5_00FF);
    run_sweep(13);

    load_word(32'hFFFF_FFFF, 4);
    eval_all(32'hFFFF_FFFF);
    run_sweep(32);

    // Simultaneous starts in IDLE: load wins.
    ld_start    = 1'b1;
    sweep_start = 1'b1;
    cycle();
    ld_start    = 1'b0;
    sweep_start = 1'b0;
    check("prio_ld_ready", {63'd0, ld_ready}, 64'd1);
    check("prio_no_sweep", {63'd0, sweep_busy}, 64'd0);

    load_word(32'h0000_BBAA, 2);
    load_word(32'h4433_2211, 4);
    eval_all(32'h4433_2211);

    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = LOAD_W'($urandom);
      cycle();
      check("idle_ld_ready_hold", {63'd0, ld_ready}, 64'd0);
    end
    ld_valid = 1'b0;
    run_sweep($countones(m_tt));
    eval_all(32'h4433_2211);

    repeat (3) begin
      w = TT_D'($urandom);
      load_word(w, 4);
      repeat (10) cycle();
      eval_all(m_tt);
      run_sweep($countones(m_tt));
    end

    // Asynchronous reset in the middle of a sweep.
    sweep_start = 1'b1;
    cycle();
    sweep_start = 1'b0;
    repeat (9) cycle();
    check("pre_rst_busy", {63'd0, sweep_busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    m_tt  = '0;
    m_out = 1'b0;
    check("arst_busy", {63'd0, sweep_busy}, 64'd0);
    check("arst_done", {63'd0, sweep_done}, 64'd0);
    check("arst_count", {58'd0, sweep_count}, 64'd0);
    check("arst_out", {63'd0, out}, 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sweep_done !== 1'b0 || sweep_busy !== 1'b0)
        check("post_rst_idle", {62'd0, sweep_busy, sweep_done}, 64'd0);
    end
    check("post_rst_no_done", {63'd0, sweep_done}, 64'd0);
    eval_all(32'h0);
    run_sweep(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete (got running, expected finished)");
    $fatal(1, "timeout");
  end

endmodule
